// File: rtl/iob_wishbone2iob.sv
// iob_wishbone2iob: Wishbone B4 classic-cycle slave to IOb native master bridge.
// Handles one Wishbone transfer at a time. Each transfer becomes exactly one IOb
// transaction, except a write with no byte lanes selected, which is acknowledged
// locally. The request is registered, so IOb outputs never see Wishbone glitches.

module iob_wishbone2iob #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,

  // Wishbone slave side
  input  logic [ADDR_W-1:0]     wb_addr_i,
  input  logic [DATA_W/8-1:0]   wb_select_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic                  wb_ack_o,
  output logic [DATA_W-1:0]     wb_data_o,

  // IOb master side
  output logic                  iob_valid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  state_t              state_q;
  logic                valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   sel_q;
  logic                we_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                wb_req_c;
  logic                null_wr_c;

  // A Wishbone request is pending; a write with no lanes selected never reaches IOb
  assign wb_req_c  = wb_cyc_i & wb_stb_i;
  assign null_wr_c = wb_we_i & (wb_select_i == '0);

  // Transfer FSM plus request/response registers; everything freezes when cke_i is low
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else if (cke_i) begin
      case (state_q)
        ST_IDLE: begin
          if (wb_req_c) begin
            addr_q  <= wb_addr_i;
            wdata_q <= wb_data_i;
            sel_q   <= wb_select_i;
            we_q    <= wb_we_i;
            if (null_wr_c) begin
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_REQ;
              valid_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // Request is held stable until the target accepts it; IOb cannot abort
          if (iob_ready_i) begin
            valid_q <= 1'b0;
            state_q <= we_q ? ST_ACK : ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          if (iob_rvalid_i) begin
            rdata_q <= iob_rdata_i;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The ack is gated by the live cycle/strobe so an aborted transfer drains silently
  assign wb_ack_o    = (state_q == ST_ACK) & wb_cyc_i & wb_stb_i;
  assign wb_data_o   = rdata_q;

  assign iob_valid_o = valid_q;
  assign iob_addr_o  = addr_q;
  assign iob_wdata_o = wdata_q;
  assign iob_wstrb_o = we_q ? sel_q : STRB_W'(0);

endmodule

// File: doc/iob_wishbone2iob.md
# iob_wishbone2iob

Wishbone B4 classic-cycle slave to IOb native master bridge: converts one Wishbone transfer at a time into one IOb transaction and returns the acknowledge and read data to the Wishbone master. It is the companion stage to the IOb-to-Wishbone bridge. It lets a Wishbone-only master, such as a third-party CPU or DMA, drive IOb peripherals and memories. Registered, non-pipelined, one outstanding transfer.

## Interface
- ADDR_W, 32, address width (Wishbone and IOb)
- DATA_W, 32, data width; DATA_W/8 byte lanes

- clk_i  in  1  clock
- cke_i  in  1  clock enable; when low every register holds
- rst_i  in  1  reset; one clock, synchronous and active-high
- wb_addr_i  in  ADDR_W  Wishbone address
- wb_select_i  in  DATA_W/8  byte select
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_data_i  in  DATA_W  write data
- wb_ack_o  out  1  acknowledge
- wb_data_o  out  DATA_W  read data
- iob_valid_o  out  1  IOb request valid
- iob_addr_o  out  ADDR_W  IOb address
- iob_wdata_o  out  DATA_W  IOb write data
- iob_wstrb_o  out  DATA_W/8  write strobe; 0 means read
- iob_ready_i  in  1  IOb request accepted
- iob_rvalid_i  in  1  IOb read data valid
- iob_rdata_i  in  DATA_W  IOb read data

## Operation
- Request registers hold addr, wdata, sel and we.
  - Loaded only in IDLE when wb_cyc_i & wb_stb_i.
  - Drive iob_addr_o and iob_wdata_o directly.
  - iob_wstrb_o = we_r ? sel_r : 0.
- State machine has four states.
  - IDLE: iob_valid_o=0. On cyc&stb:
    - if wb_we_i and wb_select_i==0, capture and go to ACK (null write; no IOb transaction).
    - otherwise, capture and go to REQ.
  - REQ: iob_valid_o=1; the request is held stable until iob_ready_i.
    - On ready with we_r=1: go to ACK.
    - On ready with we_r=0: go to WAIT_RD.
  - WAIT_RD: iob_valid_o=0. On iob_rvalid_i: load rd_data_r with iob_rdata_i and go to ACK.
  - ACK: go to IDLE unconditionally.
- wb_ack_o = (state==ACK) & wb_cyc_i & wb_stb_i.
- wb_data_o = rd_data_r; holds the last read value and is updated only in WAIT_RD on rvalid.
- iob_rvalid_i outside WAIT_RD is ignored.
- Master abort: wb_cyc_i dropping in REQ or WAIT_RD does not cancel the IOb transaction (IOb cannot abort). The FSM finishes normally; the ACK state then produces no ack because cyc is low.
- A new Wishbone request is sampled only in IDLE. Back-to-back transfers therefore have at least one IDLE cycle between ack and the next capture.

## Timing
- Reset values: state=IDLE, iob_valid_o=0, wb_ack_o=0, wb_data_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0.
- Reset takes effect at the next rising edge regardless of cke_i.
- Reset mid-transaction abandons it; no ack is issued.
- Cycle 0 is the first cycle with cyc&stb in IDLE.
  - Write, zero-wait target: iob_valid_o in cycle 1, ready in cycle 1, wb_ack_o in cycle 2 (latency 2).
  - Read, zero-wait target: valid/ready in cycle 1, rvalid in cycle 2, wb_ack_o with data in cycle 3 (latency 3).
  - Each IOb wait cycle on ready or rvalid adds exactly one cycle.
- Null write: wb_ack_o in cycle 1; iob_valid_o never asserts.
- wb_ack_o is high for exactly one cycle per transfer.
- Throughput: write 1 transfer per 3 cycles, read 1 per 4 (zero-wait, master re-asserts stb in the cycle after ack).
- With cke_i=0 the FSM and all registers freeze. Outputs stay at their current values, and wb_ack_o may stay high while frozen.

## Test plan
- Reset: assert rst_i for 2 cycles with random inputs -> all outputs 0, state IDLE. Release, then idle 5 cycles -> iob_valid_o stays 0.
- Write: addr=0x100, data=0xDEADBEEF, sel=0xF, we=1, ready tied high -> iob_valid_o cycle 1 with wstrb=0xF and wdata=0xDEADBEEF; wb_ack_o cycle 2 for exactly one cycle.
- Read with waits: addr=0x204, we=0, ready after 2 wait cycles, rvalid 3 cycles after ready with rdata=0x12345678 -> iob_wstrb_o=0; iob_valid_o held 3 cycles; ack with wb_data_o=0x12345678; wb_data_o still 0x12345678 after ack.
- Null write: we=1, sel=0 -> ack in cycle 1; iob_valid_o never asserts.
- Abort: read issued, cyc and stb dropped in the cycle after capture, rvalid arrives later -> wb_ack_o never asserts; FSM back in IDLE; the next write completes normally.
- Back-to-back plus cke: 8 alternating writes and reads, cke_i toggled randomly -> 8 acks in order, read data matches the model, and iob_valid_o never drops before ready.
